mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 188 ++++++++++++++++++
 tb/tb_mem_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: sequences 32-bit load/store requests from the control unit
// into byte-wide SRAM cycles, assembling and sign/zero-extending read data.
module mem_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_size,
    input  logic        mem_addr_ready,
    output logic        mem_data_ready,
    output logic [31:0] rdata,
    output logic        bus_oe,
    output logic [18:0] sram_addr,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [7:0]  sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_in
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        DONE,
        RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  last_q, last_d;
    logic [18:0] base_q, base_d;
    logic [3:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged;

    // Upper address bits fall outside the SRAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:19];

    // Index of the final byte: one-hot byte/half sizes, anything else is a word.
    function automatic logic [1:0] last_index(input logic [3:0] size);
        case (size)
            4'b1000, 4'b0100: last_index = 2'd0;
            4'b0010, 4'b0001: last_index = 2'd1;
            default:          last_index = 2'd3;
        endcase
    endfunction

    // Width extension of the assembled load value according to the size code.
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [3:0] size);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = raw[7:0];
        h = raw[15:0];
        case (size)
            4'b1000: begin s = b; extend_load = s; end
            4'b0100: extend_load = {24'h000000, raw[7:0]};
            4'b0010: begin s = h; extend_load = s; end
            4'b0001: extend_load = {16'h0000, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // Control state and result registers; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            result_q <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
        end
    end

    // Request attributes captured at the start of an access.
    always_ff @(posedge clk) begin
        base_q    <= base_d;
        size_q    <= size_d;
        wdata_q   <= wdata_d;
        last_q    <= last_d;
        is_read_q <= is_read_d;
    end

    // Next-state logic: byte sequencing, abort handling and read assembly.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        base_d    = base_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        result_d  = result_q;
        rdata_d   = rdata_q;
        merged    = result_q;
        merged[{k_q, 3'b000} +: 8] = sram_dq_in;

        case (state_q)
            IDLE: begin
                if (mem_addr_ready && (mem_read || mem_write)) begin
                    base_d    = addr[18:0];
                    size_d    = mem_size;
                    wdata_d   = wdata;
                    is_read_d = mem_read;
                    last_d    = last_index(mem_size);
                    k_d       = 2'd0;
                    result_d  = 32'h0;
                    state_d   = mem_read ? RD : WR_SETUP;
                end
            end
            RD: begin
                if (!mem_addr_ready) begin
                    k_d     = 2'd0;
                    state_d = IDLE;
                end else begin
                    result_d = merged;
                    if (k_q == last_q) begin
                        rdata_d = extend_load(merged, size_q);
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            WR_SETUP: begin
                if (!mem_addr_ready) begin
                    k_d     = 2'd0;
                    state_d = IDLE;
                end else begin
                    state_d = WR_STROBE;
                end
            end
            WR_STROBE: begin
                // The strobe of this cycle always completes; abort only stops what follows.
                if (!mem_addr_ready) begin
                    k_d     = 2'd0;
                    state_d = IDLE;
                end else if (k_q == last_q) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = WR_SETUP;
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!mem_addr_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: purely from registered state, no input-to-output paths.
    logic rd_active;
    logic wr_active;
    assign rd_active = (state_q == RD);
    assign wr_active = (state_q == WR_SETUP) || (state_q == WR_STROBE);

    assign sram_cs_n      = !(rd_active || wr_active);
    assign sram_oe_n      = !rd_active;
    assign sram_we_n      = (state_q != WR_STROBE);
    assign sram_dq_oe     = wr_active;
    assign sram_addr      = (rd_active || wr_active) ? (base_q + {17'b0, k_q}) : 19'h0;
    assign sram_dq_out    = wr_active ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;
    assign mem_data_ready = (state_q == DONE);
    assign bus_oe         = (state_q == DONE) && is_read_q;
    assign rdata          = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed accesses with a scoreboard of expected SRAM reads,
// SRAM writes and completions, checked by independent monitors.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_size;
    logic        mem_addr_ready;
    logic        mem_data_ready;
    logic [31:0] rdata;
    logic        bus_oe;
    logic [18:0] sram_addr;
    logic        sram_cs_n, sram_oe_n, sram_we_n;
    logic [7:0]  sram_dq_out;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_in;

    always #5 clk = ~clk;

    mem_bridge dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr_ready(mem_addr_ready), .mem_data_ready(mem_data_ready),
        .rdata(rdata), .bus_oe(bus_oe), .sram_addr(sram_addr),
        .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    // SRAM model with a bench-side preload port
    logic [7:0]  mem [0:524287];
    logic        pl_en = 1'b0;
    logic [18:0] pl_addr = 19'h0;
    logic [7:0]  pl_data = 8'h0;

    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!sram_cs_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
    end

    typedef struct {
        logic        rd;
        logic [31:0] rdata;
        int          cyc;
    } done_t;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    done_t       done_q[$];
    wr_t         wr_q[$];
    logic [18:0] rd_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          we_low = 0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Read-cycle monitor
    always @(negedge clk) begin
        if (!sram_cs_n && !sram_oe_n) begin
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_read: addr %h want none", sram_addr);
            end else begin
                chk("rd_addr", {13'h0, sram_addr}, {13'h0, rd_q.pop_front()});
            end
        end
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        if (!sram_we_n) we_low++;
        if (!sram_cs_n && !sram_we_n) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: addr %h data %h want none", sram_addr, sram_dq_out);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_strobe", {4'h0, sram_addr, sram_dq_out, sram_dq_oe}, {4'h0, w.a, w.d, 1'b1});
            end
        end
    end

    // Completion monitor plus protocol invariants
    always @(negedge clk) begin
        if (mem_data_ready) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: rdata %h want no completion", rdata);
            end else begin
                done_t e;
                e = done_q.pop_front();
                chk("done_bus_oe", {31'h0, bus_oe}, {31'h0, e.rd});
                chk("done_rdata", rdata, e.rdata);
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (!sram_oe_n && !sram_we_n) begin
            bad++;
            $display("FAIL oe_we_overlap: oe_n=%b we_n=%b want not both 0", sram_oe_n, sram_we_n);
        end
        if (bus_oe && !mem_data_ready) begin
            bad++;
            $display("FAIL bus_oe_outside_done: bus_oe=%b want 0", bus_oe);
        end
    end

    task automatic preload(input logic [18:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drive a request at a negedge while the DUT is idle; push expectations.
    task automatic issue(input logic rd, input logic wr, input logic [3:0] size,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input int n,
                         input logic push_done, input int nexp);
        done_t d;
        wr_t   w;
        mem_read = rd; mem_write = wr; mem_size = size;
        addr = a; wdata = wd; mem_addr_ready = 1'b1;
        for (int i = 0; i < nexp; i++) begin
            if (rd) rd_q.push_back(a[18:0] + 19'(i));
            else begin
                w.a = a[18:0] + 19'(i);
                w.d = 8'(wd >> (8 * i));
                wr_q.push_back(w);
            end
        end
        if (push_done) begin
            d.rd    = rd;
            d.rdata = rd ? exp_rdata : last_rdata;
            d.cyc   = cyc + (rd ? (n + 1) : (2 * n + 1));
            done_q.push_back(d);
            if (rd) last_rdata = exp_rdata;
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_data_ready) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: mem_data_ready=0 want 1");
        end
    endtask

    task automatic release_bus();
        mem_addr_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [3:0] size,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input int n);
        issue(rd, wr, size, a, wd, exp_rdata, n, 1'b1, n);
        wait_done();
        release_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running want finished");
        $fatal(1);
    end

    initial begin
        int wb;
        reset = 1'b1; addr = 32'h0; wdata = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 4'h0; mem_addr_ready = 1'b0;
        @(negedge clk);
        preload(19'h00100, 8'h78); preload(19'h00101, 8'h56);
        preload(19'h00102, 8'h34); preload(19'h00103, 8'h12);
        preload(19'h00203, 8'h80);
        preload(19'h00010, 8'h00); preload(19'h00011, 8'h90);
        preload(19'h00501, 8'h5A);

        // Reset state
        chk("rst_strobes", {28'h0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("rst_sram_addr", {13'h0, sram_addr}, 32'h0);
        chk("rst_dq_out", {24'h0, sram_dq_out}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {30'h0, bus_oe, mem_data_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Loads of each size, multi-bit size, read+write, high address bits
        access(1, 0, 4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 4);
        access(1, 0, 4'b1000, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 1);
        access(1, 0, 4'b0100, 32'h0000_0203, 32'h0, 32'h0000_0080, 1);
        access(1, 0, 4'b0010, 32'h0000_0010, 32'h0, 32'hFFFF_9000, 2);
        access(1, 0, 4'b0001, 32'h0000_0010, 32'h0, 32'h0000_9000, 2);
        access(1, 0, 4'b1100, 32'h0000_0100, 32'h0, 32'h1234_5678, 4);
        access(1, 1, 4'b0000, 32'hFFF8_0100, 32'h0, 32'h1234_5678, 4);

        // Word store wrapping past the top of SRAM, then read it back
        wb = we_low;
        access(0, 1, 4'b0000, 32'h0007_FFFE, 32'hAABB_CCDD, 32'h0, 4);
        chk("sw_we_low_cycles", we_low - wb, 4);
        access(1, 0, 4'b0000, 32'h0007_FFFE, 32'h0, 32'hAABB_CCDD, 4);

        // Byte and half stores with read-back
        access(0, 1, 4'b1000, 32'h0000_0300, 32'h0000_00EE, 32'h0, 1);
        access(1, 0, 4'b0100, 32'h0000_0300, 32'h0, 32'h0000_00EE, 1);
        access(0, 1, 4'b0001, 32'h0000_0400, 32'h1234_BEEF, 32'h0, 2);
        access(1, 0, 4'b0010, 32'h0000_0400, 32'h0, 32'hFFFF_BEEF, 2);

        // Request held after completion must not start another access
        issue(1, 0, 4'b1000, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 1, 1'b1, 1);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_no_access", {31'h0, sram_cs_n}, 32'h1);
        end
        mem_addr_ready = 1'b0;
        @(negedge clk);
        access(1, 0, 4'b0100, 32'h0000_0203, 32'h0, 32'h0000_0080, 1);

        // Word store aborted in the second byte's setup cycle
        wb = we_low;
        issue(0, 1, 4'b0000, 32'h0000_0500, 32'h4433_2211, 32'h0, 4, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_setup_addr", {13'h0, sram_addr}, 32'h501);
        chk("abort_setup_we_dq", {30'h0, sram_we_n, sram_dq_oe}, 32'h3);
        mem_addr_ready = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("abort_idle_strobes", {28'h0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        repeat (3) @(negedge clk);
        chk("abort_we_low_cycles", we_low - wb, 1);
        chk("abort_mem", {16'h0, mem[19'h00500], mem[19'h00501]}, 32'h115A);
        access(1, 0, 4'b0100, 32'h0000_0500, 32'h0, 32'h0000_0011, 1);

        // Reset during the third byte of a word load
        issue(1, 0, 4'b0000, 32'h0000_0100, 32'h0, 32'h0, 4, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {28'h0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("midrst_sram_addr", {13'h0, sram_addr}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_flags", {30'h0, bus_oe, mem_data_ready}, 32'h0);
        last_rdata = 32'h0;
        reset = 1'b0;
        // First access after reset, without any release phase
        access(1, 0, 4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 4);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", done_q.size() + wr_q.size() + rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
